// File: rtl/tdp_ram_ctrl.sv
// True dual-port RAM with a clear sequencer, per-port read-valid strobes,
// optional output register, cross-port read-during-write policy and A-wins collision handling.
//
// state    | meaning
// ST_CLEAR | zeroing one word per cycle at cnt_q, port requests dropped, busy=1
// ST_RUN   | serving port A/B requests, clear request restarts ST_CLEAR
module tdp_ram_ctrl #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8,
    parameter int OUT_REG    = 0,
    parameter int RDW_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [WIDTH-1:0]      din_a,
    output logic [WIDTH-1:0]      dout_a,
    output logic                  valid_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [WIDTH-1:0]      din_b,
    output logic [WIDTH-1:0]      dout_b,
    output logic                  valid_b,
    output logic                  collision
);

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]        mem_q [DEPTH];

    logic                    clr_we, run;
    logic                    ok_a, ok_b, rd_a, rd_b, wr_a, wr_b;
    logic [WIDTH-1:0]        rdata_a_d, rdata_b_d;
    logic [WIDTH-1:0]        rdata_a_q, rdata_b_q;
    logic                    rvalid_a_q, rvalid_b_q;
    logic                    coll_d, coll_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // The memory has no reset, so every write strobe is masked while rst is high.
    always_comb begin
        busy   = (state_q == ST_CLEAR);
        clr_we = 1'b0;
        run    = 1'b0;
        if (!rst) begin
            clr_we = (state_q == ST_CLEAR);
            run    = (state_q == ST_RUN);
        end
    end

    assign ok_a = (32'(addr_a) < DEPTH);
    assign ok_b = (32'(addr_b) < DEPTH);
    assign rd_a = run & en_a & ~we_a;
    assign rd_b = run & en_b & ~we_b;
    assign wr_a = run & en_a & we_a & ok_a;
    assign wr_b = run & en_b & we_b & ok_b;
    assign coll_d = run & en_a & we_a & en_b & we_b & (addr_a == addr_b);

    always_comb begin
        rdata_a_d = '0;
        if (ok_a) begin
            rdata_a_d = mem_q[addr_a];
            if (RDW_MODE != 0 && wr_b && addr_b == addr_a) rdata_a_d = din_b;
        end
    end

    always_comb begin
        rdata_b_d = '0;
        if (ok_b) begin
            rdata_b_d = mem_q[addr_b];
            if (RDW_MODE != 0 && wr_a && addr_a == addr_b) rdata_b_d = din_a;
        end
    end

    // Port A is written last so it overrides B on a same-address collision.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (wr_b) mem_q[addr_b] <= din_b;
            if (wr_a) mem_q[addr_a] <= din_a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            rvalid_a_q <= rd_a;
            rvalid_b_q <= rd_b;
            coll_q     <= coll_d;
            if (rd_a) rdata_a_q <= rdata_a_d;
            if (rd_b) rdata_b_q <= rdata_b_d;
        end
    end

    assign collision = coll_q;

    if (OUT_REG != 0) begin : g_oreg
        logic [WIDTH-1:0] dout_a_q, dout_b_q;
        logic             valid_a_q, valid_b_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_a_q  <= '0;
                dout_b_q  <= '0;
                valid_a_q <= 1'b0;
                valid_b_q <= 1'b0;
            end else begin
                valid_a_q <= rvalid_a_q;
                valid_b_q <= rvalid_b_q;
                if (rvalid_a_q) dout_a_q <= rdata_a_q;
                if (rvalid_b_q) dout_b_q <= rdata_b_q;
            end
        end

        assign dout_a  = dout_a_q;
        assign dout_b  = dout_b_q;
        assign valid_a = valid_a_q;
        assign valid_b = valid_b_q;
    end else begin : g_noreg
        assign dout_a  = rdata_a_q;
        assign dout_b  = rdata_b_q;
        assign valid_a = rvalid_a_q;
        assign valid_b = rvalid_b_q;
    end

endmodule

// File: doc/tdp_ram_ctrl.md
Name: tdp_ram_ctrl

Overview:
Parametrised true dual-port RAM with access control. It adds a memory-clear sequencer, per-port read-valid strobes, an optional output pipeline register, a selectable cross-port read-during-write policy and write-write collision arbitration. Each port uses one address for both reads and writes. It is the shared coefficient/sample store for the dot-product and sorter datapaths, where both engines access the same buffer.

Parameters:
WIDTH, 8, data word width in bits
ADDR_WIDTH, 3, address width in bits
DEPTH, 8, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH
OUT_REG, 0, 0 = read data one cycle after request; 1 = extra output register, two cycles
RDW_MODE, 0, cross-port read of an address written in the same cycle: 0 = old data, 1 = new data

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous and active-high; starts a memory clear
clear  input  1  one-cycle request to zero the whole memory; honoured only while busy=0
busy  output  1  high while the clear sequence runs; port requests are ignored
en_a  input  1  port A request strobe
we_a  input  1  port A write (1) / read (0), qualified by en_a
addr_a  input  ADDR_WIDTH  port A address
din_a  input  WIDTH  port A write data
dout_a  output  WIDTH  port A read data
valid_a  output  1  dout_a holds data for a read accepted OUT_REG+1 cycles earlier
en_b, we_b, addr_b, din_b, dout_b, valid_b  as port A, for port B
collision  output  1  one-cycle pulse: both ports wrote the same address

Behaviour:
- Reset (async, rst=1): dout_a=dout_b=0, valid_a=valid_b=0, collision=0, busy=1, FSM=CLEAR, clear counter=0. Memory contents are not touched while rst is high.
- FSM has two states:
  - CLEAR: each cycle writes 0 to address cnt, then cnt increments. After writing DEPTH-1, the FSM goes to RUN on the next edge and busy falls.
  - RUN: serves port requests. If clear=1, the FSM goes to CLEAR next edge with cnt=0 and busy=1; requests in that same cycle are still served.
- Total clear time is DEPTH cycles after rst falls or after the clear edge.
- Requests arriving during CLEAR are dropped: no write, no valid strobe. dout holds its last value.
- rst asserted mid-CLEAR or mid-RUN: immediate return to the reset state; the clear restarts from address 0.
- Read (en=1, we=0):
  - OUT_REG=0: data and valid appear at edge N+1 for a request at edge N.
  - OUT_REG=1: data and valid appear at edge N+2.
  - valid is a single-cycle pulse per read. Back-to-back reads give continuous valid.
- Write (en=1, we=1): memory is updated at the edge. A write never raises valid, and dout is unchanged by a same-port write.
- Cross-port read-during-write (one port writes address X, the other reads X in the same cycle):
  - RDW_MODE=0: the reader returns the pre-write contents.
  - RDW_MODE=1: the reader returns the writer's din.
- Write-write to the same address in the same cycle: port A wins and B's data is discarded. collision=1 on the following cycle only. Writes to different addresses both complete.
- Address >= DEPTH (only possible when DEPTH < 2**ADDR_WIDTH): the write is ignored. A read returns 0 with valid asserted normally.
- Pipeline under OUT_REG=1: an in-flight read still delivers its valid even if clear is requested one cycle after the read.
- dout holds its value between reads; it is not zeroed when valid falls.

Test Plan:
- Reset clear: fill all 8 words with 0xFF, pulse rst. Expect busy=1 for exactly 8 cycles after rst falls. Then reads of addresses 0..7 return 0x00, each with one valid pulse.
- Basic latency, OUT_REG=0: write A[3]=0x5A, then read B[3]. Expect dout_b=0x5A and valid_b=1 exactly one edge after the read request. Repeat with OUT_REG=1 and expect two edges.
- RDW policy: preload A[2]=0x11. Same cycle: A writes 0x22 to address 2 while B reads address 2. RDW_MODE=0 gives dout_b=0x11; RDW_MODE=1 gives 0x22. A follow-up read returns 0x22 in both modes.
- Collision: same cycle, A writes 0xAA and B writes 0xBB to address 5. Expect collision high for one cycle, then a read of address 5 returns 0xAA. Simultaneous writes to addresses 1 and 6 complete with collision=0.
- Clear request: in RUN, pulse clear while port B reads address 4 (holding 0x77). Expect valid_b with 0x77. busy stays high for 8 cycles. Reads issued during busy produce no valid. Afterwards address 4 reads 0x00.
- Reset mid-clear: assert rst at cnt=4. Expect immediate busy=1 and all outputs 0. After release, the full 8-cycle clear completes and all words read 0.
